expr_equiv_checker: RTL and testbench
=====================================

EXPR_EQUIV_CHECKER -- requirements
Module: expr_equiv_checker

Interface
REQ-001 The block SHALL have parameter N_IN, default 3: width of the stimulus vector, legal range 1..8.
REQ-002 The block SHALL have parameter SETTLE, default 1: cycles each vector is held before sampling, legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start_i  input  1  request a sweep; sampled on clk.
REQ-006 abort_i  input  1  synchronous abort of a running sweep.
REQ-007 orig_i  input  1  response of the original expression for the current vec_o.
REQ-008 simp_i  input  1  response of the simplified expression for the current vec_o.
REQ-009 vec_o  output  N_IN  stimulus vector; bit N_IN-1 = A (MSB), bit 0 = C (LSB) for N_IN=3.
REQ-010 busy_o  output  1  high in states DRIVE and SAMPLE.
REQ-011 done_o  output  1  high in state DONE only.
REQ-012 pass_o  output  1  high in DONE when mismatch_cnt_o==0; low in all other states.
REQ-013 mismatch_cnt_o  output  N_IN+1  number of mismatching vectors in the current or last sweep.
REQ-014 fail_valid_o  output  1  high once a mismatch is captured in the current or last sweep.
REQ-015 first_fail_o  output  N_IN  vector of the first mismatch; meaningful only when fail_valid_o=1.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, DRIVE, SAMPLE and DONE, all registered.
REQ-017 In IDLE or DONE with start_i=1, the next state SHALL be DRIVE, with vec_o<=0, mismatch_cnt_o<=0, fail_valid_o<=0, first_fail_o<=0 and settle counter<=SETTLE-1.
REQ-018 In DRIVE, the settle counter SHALL decrement each cycle, and the next state SHALL be SAMPLE on the cycle the counter equals 0; vec_o SHALL stay stable in DRIVE.
REQ-019 SAMPLE SHALL last one cycle; on its closing edge, orig_i!=simp_i SHALL count as a mismatch.
REQ-020 On a mismatch, mismatch_cnt_o SHALL increment by 1; if fail_valid_o=0, first_fail_o<=vec_o and fail_valid_o<=1. Later mismatches SHALL NOT overwrite first_fail_o.
REQ-021 Leaving SAMPLE with vec_o!=all-ones, vec_o SHALL increment by 1, the counter SHALL reload to SETTLE-1, and the next state SHALL be DRIVE.
REQ-022 Leaving SAMPLE with vec_o==all-ones, the next state SHALL be DONE; vec_o SHALL hold all-ones and SHALL NOT wrap.
REQ-023 Latency: done_o SHALL rise exactly 2^N_IN*(SETTLE+1) cycles after the edge that accepts start_i (16 cycles at the defaults).
REQ-024 mismatch_cnt_o SHALL NOT saturate and SHALL be able to hold 2^N_IN.
REQ-025 start_i SHALL be ignored in DRIVE and SAMPLE.
REQ-026 DONE SHALL hold done_o, pass_o and the result outputs until start_i or abort_i.
REQ-027 abort_i=1 in any state SHALL force IDLE on the next edge, with vec_o, counters and result outputs cleared to 0.
REQ-028 abort_i SHALL take priority over start_i when both are high.
REQ-029 An orig_i or simp_i value of X/Z at the sample edge SHALL be treated as a mismatch (case-inequality compare).

Reset
REQ-030 On rst_n low, the block SHALL asynchronously enter IDLE with vec_o=0, busy_o=0, done_o=0, pass_o=0, mismatch_cnt_o=0, fail_valid_o=0, first_fail_o=0 and settle counter=0.
REQ-031 Deasserting rst_n SHALL take effect on the next clk edge; the first start_i is accepted at that edge if high.
REQ-032 Reset asserted mid-sweep SHALL discard all partial results; no done_o pulse SHALL follow.

Verification
REQ-033 Defaults, orig_i=simp_i=(A&B)|C combinational from vec_o, pulse start_i -> done_o=1 at cycle 16, pass_o=1, mismatch_cnt_o=0, fail_valid_o=0.
REQ-034 simp_i=~orig_i for all vectors -> mismatch_cnt_o=8, first_fail_o=3'b000, pass_o=0.
REQ-035 Mismatch only at vec_o=3'b101 -> mismatch_cnt_o=1, first_fail_o=3'b101, fail_valid_o=1; repeating with an additional mismatch at 3'b110 -> mismatch_cnt_o=2, first_fail_o still 3'b101.
REQ-036 SETTLE=3 with a start_i pulse re-asserted at cycle 5 -> the second pulse is ignored, vec_o advances every 4 cycles, and done_o rises at cycle 32.
REQ-037 rst_n low at cycle 7 of a sweep -> all outputs 0 immediately (before the next edge); abort_i with start_i at cycle 7 in a separate run -> IDLE next cycle with outputs 0.
REQ-038 start_i in DONE after a failing sweep -> results clear on the accepting edge and a passing second sweep ends with pass_o=1.

Source files
------------

// File: rtl/expr_equiv_checker.sv
// Exhaustive equivalence checker for two single-output combinational
// expressions. Sweeps every N_IN-bit input vector, holds each one for
// SETTLE cycles, then compares the two responses for one cycle. It reports
// the mismatch count and the first failing vector.
//
// Handshake: start_i is a level request sampled on every rising edge. It is
// accepted only in IDLE or DONE, and the accepting edge moves the FSM to
// DRIVE. While busy_o is high (DRIVE/SAMPLE), start_i is ignored. abort_i is
// sampled on every edge, wins over start_i, and returns the block to IDLE
// with all results cleared. There is no ready signal: the block is ready for
// start_i exactly when busy_o is low.
module expr_equiv_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            orig_i,
  input  logic            simp_i,
  output logic [N_IN-1:0] vec_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   mismatch_cnt_o,
  output logic            fail_valid_o,
  output logic [N_IN-1:0] first_fail_o,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Reload value for the settle counter. Four bits cover SETTLE up to 15.
  localparam logic [3:0]      SETTLE_RELOAD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST      = '1;
  localparam logic [N_IN:0]   CNT_ONE       = (N_IN+1)'(1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;

  logic mismatch;
  logic settle_zero;
  logic last_vec;
  logic accept_start;

  // Case inequality, so an X/Z response in simulation counts as a mismatch.
  assign mismatch     = (orig_i !== simp_i);
  assign settle_zero  = (settle_cnt == 4'd0);
  assign last_vec     = (vec_o == VEC_LAST);
  assign accept_start = start_i && ((state == S_IDLE) || (state == S_DONE));
  assign state_dbg    = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start_i) state_nxt = S_DRIVE;
        S_DRIVE:  if (settle_zero) state_nxt = S_SAMPLE;
        S_SAMPLE: state_nxt = last_vec ? S_DONE : S_DRIVE;
        S_DONE:   if (start_i) state_nxt = S_DRIVE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    pass_o = 1'b0;
    case (state)
      S_DRIVE:  busy_o = 1'b1;
      S_SAMPLE: busy_o = 1'b1;
      S_DONE: begin
        done_o = 1'b1;
        pass_o = (mismatch_cnt_o == '0);
      end
      default: ;
    endcase
  end

  // Datapath: stimulus vector, settle timer and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_o          <= '0;
      settle_cnt     <= 4'd0;
      mismatch_cnt_o <= '0;
      fail_valid_o   <= 1'b0;
      first_fail_o   <= '0;
    end else if (abort_i) begin
      vec_o          <= '0;
      settle_cnt     <= 4'd0;
      mismatch_cnt_o <= '0;
      fail_valid_o   <= 1'b0;
      first_fail_o   <= '0;
    end else if (accept_start) begin
      // A new sweep discards whatever the previous one left behind.
      vec_o          <= '0;
      settle_cnt     <= SETTLE_RELOAD;
      mismatch_cnt_o <= '0;
      fail_valid_o   <= 1'b0;
      first_fail_o   <= '0;
    end else begin
      case (state)
        S_DRIVE: begin
          if (!settle_zero) settle_cnt <= settle_cnt - 4'd1;
        end
        S_SAMPLE: begin
          if (mismatch) begin
            mismatch_cnt_o <= mismatch_cnt_o + CNT_ONE;
            if (!fail_valid_o) begin
              first_fail_o <= vec_o;
              fail_valid_o <= 1'b1;
            end
          end
          // The last vector stays on vec_o through DONE instead of wrapping.
          if (!last_vec) begin
            vec_o      <= vec_o + 1'b1;
            settle_cnt <= SETTLE_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_equiv_checker.sv
// Directed bench for expr_equiv_checker. One instance uses the default
// parameters and a selectable simplified-expression fault. A second instance
// uses SETTLE=3 with a fault-free expression.
module tb_expr_equiv_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- DUT A: defaults ----------------
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       orig;
  logic       simp;
  logic [2:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] cnt;
  logic       fv;
  logic [2:0] ff;
  logic [1:0] st;
  int         mode = 0;

  // orig = (A&B)|C; simp is orig with faults injected at selected vectors.
  always_comb begin
    orig = (vec[2] & vec[1]) | vec[0];
    simp = orig;
    case (mode)
      1: simp = ~orig;
      2: if (vec == 3'b101) simp = ~orig;
      3: if (vec == 3'b101 || vec == 3'b110) simp = ~orig;
      4: if (vec == 3'b111) simp = ~orig;
      default: simp = orig;
    endcase
  end

  expr_equiv_checker #(.N_IN(3), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .orig_i(orig), .simp_i(simp), .vec_o(vec), .busy_o(busy),
    .done_o(done), .pass_o(pass), .mismatch_cnt_o(cnt),
    .fail_valid_o(fv), .first_fail_o(ff), .state_dbg(st)
  );

  // ---------------- DUT B: SETTLE=3 ----------------
  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic       orig2;
  logic [2:0] vec2;
  logic       busy2;
  logic       done2;
  logic       pass2;
  logic [3:0] cnt2;
  logic       fv2;
  logic [2:0] ff2;
  logic [1:0] st2;

  assign orig2 = (vec2[2] & vec2[1]) | vec2[0];

  expr_equiv_checker #(.N_IN(3), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .abort_i(abort2),
    .orig_i(orig2), .simp_i(orig2), .vec_o(vec2), .busy_o(busy2),
    .done_o(done2), .pass_o(pass2), .mismatch_cnt_o(cnt2),
    .fail_valid_o(fv2), .first_fail_o(ff2), .state_dbg(st2)
  );

  // ---------------- driver tasks ----------------
  // Pulse start for one edge; returns #1 after the accepting edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges from the accepting edge until done is seen (capped at 100).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (st !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", st); end
    checks++; if ({vec, busy, done, pass, cnt, fv, ff} !== 15'd0) begin failures++; $display("FAIL reset_outputs: got %0h expected 0", {vec, busy, done, pass, cnt, fv, ff}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (st !== 2'd0) begin failures++; $display("FAIL idle_after_reset: got %0d expected 0", st); end
  endtask

  task automatic test_pass_sweep();
    int n;
    mode = 0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start: got %0b expected 1", busy); end
    wait_done(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL latency_default: got %0d expected 16", n); end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL pass_equal: got %0b expected 1", pass); end
    checks++; if (cnt !== 4'd0) begin failures++; $display("FAIL cnt_equal: got %0d expected 0", cnt); end
    checks++; if (fv !== 1'b0) begin failures++; $display("FAIL fv_equal: got %0b expected 0", fv); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_in_done: got %0b expected 0", busy); end
    checks++; if (vec !== 3'b111) begin failures++; $display("FAIL vec_last: got %0b expected 111", vec); end
  endtask

  task automatic test_all_mismatch();
    int n;
    mode = 1;
    pulse_start();
    wait_done(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL latency_all_mis: got %0d expected 16", n); end
    checks++; if (cnt !== 4'd8) begin failures++; $display("FAIL cnt_all_mis: got %0d expected 8", cnt); end
    checks++; if (ff !== 3'b000) begin failures++; $display("FAIL ff_all_mis: got %0b expected 000", ff); end
    checks++; if (fv !== 1'b1) begin failures++; $display("FAIL fv_all_mis: got %0b expected 1", fv); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL pass_all_mis: got %0b expected 0", pass); end
    // DONE holds results and vec must not wrap.
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({done, vec, cnt} !== {1'b1, 3'b111, 4'd8}) begin failures++; $display("FAIL done_hold: got %0h expected %0h", {done, vec, cnt}, {1'b1, 3'b111, 4'd8}); end
  endtask

  task automatic test_first_fail();
    int n;
    mode = 2;
    pulse_start();
    // Restarting from DONE clears the previous results on the accepting edge.
    checks++; if ({cnt, fv, ff, done} !== 9'd0) begin failures++; $display("FAIL clear_on_restart: got %0h expected 0", {cnt, fv, ff, done}); end
    wait_done(n);
    checks++; if ({cnt, fv, ff} !== {4'd1, 1'b1, 3'b101}) begin failures++; $display("FAIL single_101: got %0h expected %0h", {cnt, fv, ff}, {4'd1, 1'b1, 3'b101}); end
    mode = 3;
    pulse_start();
    wait_done(n);
    checks++; if ({cnt, fv, ff} !== {4'd2, 1'b1, 3'b101}) begin failures++; $display("FAIL double_101_110: got %0h expected %0h", {cnt, fv, ff}, {4'd2, 1'b1, 3'b101}); end
    mode = 4;
    pulse_start();
    wait_done(n);
    checks++; if ({cnt, fv, ff, pass} !== {4'd1, 1'b1, 3'b111, 1'b0}) begin failures++; $display("FAIL last_vec_mis: got %0h expected %0h", {cnt, fv, ff, pass}, {4'd1, 1'b1, 3'b111, 1'b0}); end
  endtask

  task automatic test_restart_pass();
    int n;
    mode = 0;
    pulse_start();
    wait_done(n);
    checks++; if ({pass, cnt, fv} !== {1'b1, 4'd0, 1'b0}) begin failures++; $display("FAIL restart_pass: got %0h expected %0h", {pass, cnt, fv}, {1'b1, 4'd0, 1'b0}); end
  endtask

  task automatic test_settle3();
    int n;
    logic [2:0] v3;
    logic [2:0] v4;
    logic [2:0] v8;
    v3 = 3'bxxx; v4 = 3'bxxx; v8 = 3'bxxx;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      @(posedge clk); #1;
      n++;
      start2 = (n == 4);  // sampled at edge 5, mid-sweep
      if (n == 3) v3 = vec2;
      if (n == 4) v4 = vec2;
      if (n == 8) v8 = vec2;
    end
    start2 = 1'b0;
    checks++; if (v3 !== 3'd0) begin failures++; $display("FAIL s3_vec_c3: got %0b expected 000", v3); end
    checks++; if (v4 !== 3'd1) begin failures++; $display("FAIL s3_vec_c4: got %0b expected 001", v4); end
    checks++; if (v8 !== 3'd2) begin failures++; $display("FAIL s3_vec_c8: got %0b expected 010", v8); end
    checks++; if (n !== 32) begin failures++; $display("FAIL s3_latency: got %0d expected 32", n); end
    checks++; if (pass2 !== 1'b1) begin failures++; $display("FAIL s3_pass: got %0b expected 1", pass2); end
  endtask

  task automatic test_reset_mid_sweep();
    int seen;
    mode = 1;
    pulse_start();
    repeat (7) @(posedge clk);
    #1;
    checks++; if ({cnt, vec} !== {4'd3, 3'd3}) begin failures++; $display("FAIL pre_reset_progress: got %0h expected %0h", {cnt, vec}, {4'd3, 3'd3}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({vec, busy, done, pass, cnt, fv, ff, st} !== 17'd0) begin failures++; $display("FAIL async_reset: got %0h expected 0", {vec, busy, done, pass, cnt, fv, ff, st}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL no_done_after_reset: got %0d expected 0", seen); end
    checks++; if (st !== 2'd0) begin failures++; $display("FAIL idle_after_mid_reset: got %0d expected 0", st); end
  endtask

  task automatic test_abort();
    int n;
    mode = 1;
    pulse_start();
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    checks++; if ({st, vec, busy, cnt, fv, ff} !== 14'd0) begin failures++; $display("FAIL abort_over_start: got %0h expected 0", {st, vec, busy, cnt, fv, ff}); end
    abort = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (st !== 2'd0) begin failures++; $display("FAIL stay_idle_after_abort: got %0d expected 0", st); end
    // Abort out of DONE after a failing sweep.
    pulse_start();
    wait_done(n);
    checks++; if ({done, cnt} !== {1'b1, 4'd8}) begin failures++; $display("FAIL sweep_before_abort: got %0h expected %0h", {done, cnt}, {1'b1, 4'd8}); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if ({done, pass, vec, cnt, fv, ff, st} !== 15'd0) begin failures++; $display("FAIL abort_in_done: got %0h expected 0", {done, pass, vec, cnt, fv, ff, st}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_pass_sweep();
    test_all_mismatch();
    test_first_fail();
    test_restart_pass();
    test_settle3();
    test_reset_mid_sweep();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
